// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: default sizing, lane indices,
// song IDs, FSM state encoding and the note rule for the built-in song.
package song_pkg;

  localparam int NUM_LANES_DEF      = 3;
  localparam int SONG_LEN_DEF       = 100;
  localparam int NUM_SONGS_DEF      = 4;
  localparam int SEL_W_DEF          = 5;
  localparam int TICKS_PER_BEAT_DEF = 12500000;
  localparam int WINDOW_DEF         = 16;
  localparam int BEAT_W             = 7;

  localparam int LANE_RED    = 0;
  localparam int LANE_YELLOW = 1;
  localparam int LANE_BLUE   = 2;

  // Song IDs; the ROM decodes against these, so remapping happens here only.
  localparam int SONG_TTFAF = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Note rule for SONG_TTFAF: red on even beats from 10, yellow every fourth
  // beat from 11, blue every fourth beat from 13.
  function automatic logic ttfaf_note(input int lane, input int beat);
    logic note;
    note = 1'b0;
    if (lane == LANE_RED) begin
      note = (beat >= 10) && ((beat % 2) == 0);
    end else if (lane == LANE_YELLOW) begin
      note = (beat >= 11) && (((beat - 11) % 4) == 0);
    end else if (lane == LANE_BLUE) begin
      note = (beat >= 13) && (((beat - 13) % 4) == 0);
    end
    return note;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Combinational song pattern ROM. Lane L occupies [L*SONG_LEN +: SONG_LEN],
// with beat 0 in the MSB of each lane field. Unknown IDs give silence.
module song_rom
  import song_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int SONG_LEN  = SONG_LEN_DEF,
  parameter int SEL_W     = SEL_W_DEF
) (
  input  logic [SEL_W-1:0]              song_id,
  output logic [NUM_LANES*SONG_LEN-1:0] pattern
);

  logic [NUM_LANES*SONG_LEN-1:0] w_ttfaf;

  // Constant pattern built from the note rule, one bit per lane and beat.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      for (genvar gb = 0; gb < SONG_LEN; gb++) begin : g_beat
        assign w_ttfaf[gi*SONG_LEN + SONG_LEN - 1 - gb] = ttfaf_note(gi, gb);
      end
    end
  endgenerate

  // Select the pattern for the requested song ID.
  always_comb begin
    pattern = '0;
    if (song_id == SEL_W'(SONG_TTFAF)) begin
      pattern = w_ttfaf;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: loads a ROM pattern into per-lane shift registers and
// advances one beat every TICKS_PER_BEAT clocks, with pause/abort/done.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NUM_LANES      = NUM_LANES_DEF,
  parameter int SONG_LEN       = SONG_LEN_DEF,
  parameter int NUM_SONGS      = NUM_SONGS_DEF,
  parameter int SEL_W          = SEL_W_DEF,
  parameter int TICKS_PER_BEAT = TICKS_PER_BEAT_DEF,
  parameter int WINDOW         = WINDOW_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        pause,
  input  logic [SEL_W-1:0]            song_select,
  output logic [NUM_LANES-1:0]        note_now,
  output logic [NUM_LANES*WINDOW-1:0] lane_window,
  output logic                        beat_pulse,
  output logic [BEAT_W-1:0]           beat_idx,
  output logic                        playing,
  output logic                        done,
  output logic                        sel_err
);

  localparam int                TICK_W    = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(SONG_LEN - 1);
  localparam logic [SEL_W:0]    SEL_LIMIT = (SEL_W + 1)'(NUM_SONGS);

  state_e                        r_state;
  state_e                        w_state_next;
  logic [TICK_W-1:0]             r_tick;
  logic [BEAT_W-1:0]             r_beat_idx;
  logic [SEL_W-1:0]              r_sel;
  logic                          r_beat_pulse;
  logic                          r_sel_err;
  logic [SONG_LEN-1:0]           r_lanes [NUM_LANES];
  logic [NUM_LANES*SONG_LEN-1:0] w_pattern;

  logic w_sel_ok;
  logic w_beat_wrap;
  logic w_last_beat;
  logic w_clear;
  logic w_latch;
  logic w_reject;
  logic w_load;
  logic w_advance;
  logic w_tick_inc;

  assign w_sel_ok    = ({1'b0, song_select} < SEL_LIMIT);
  assign w_beat_wrap = (r_tick == TICK_LAST);
  assign w_last_beat = (r_beat_idx == BEAT_LAST);

  song_rom #(
    .NUM_LANES (NUM_LANES),
    .SONG_LEN  (SONG_LEN),
    .SEL_W     (SEL_W)
  ) u_rom (
    .song_id (r_sel),
    .pattern (w_pattern)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control; abort overrides everything, pause
  // wins over a beat edge falling in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_latch      = 1'b0;
    w_reject     = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_tick_inc   = 1'b0;
    if (abort) begin
      w_state_next = ST_IDLE;
      w_clear      = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (w_sel_ok) begin
              w_latch      = 1'b1;
              w_state_next = ST_LOAD;
            end else begin
              w_reject = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          w_load       = 1'b1;
          w_state_next = ST_PLAY;
        end
        ST_PLAY: begin
          if (pause) begin
            w_state_next = ST_PAUSED;
          end else if (w_beat_wrap) begin
            w_advance = 1'b1;
            if (w_last_beat) begin
              w_state_next = ST_DONE;
            end
          end else begin
            w_tick_inc = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            w_state_next = ST_PLAY;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Tick/beat counters, latched select and the registered strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tick       <= '0;
      r_beat_idx   <= '0;
      r_sel        <= '0;
      r_beat_pulse <= 1'b0;
      r_sel_err    <= 1'b0;
    end else begin
      r_beat_pulse <= w_advance;
      r_sel_err    <= w_reject;
      if (w_clear) begin
        r_tick     <= '0;
        r_beat_idx <= '0;
        r_sel      <= '0;
      end else begin
        if (w_latch) begin
          r_sel <= song_select;
        end
        if (w_load) begin
          r_tick     <= '0;
          r_beat_idx <= '0;
        end else if (w_advance) begin
          r_tick <= '0;
          if (!w_last_beat) begin
            r_beat_idx <= r_beat_idx + BEAT_W'(1);
          end
        end else if (w_tick_inc) begin
          r_tick <= r_tick + TICK_W'(1);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Per-lane pattern shift register; zeros shift in behind the song.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_lanes[gi] <= '0;
        end else if (w_clear) begin
          r_lanes[gi] <= '0;
        end else if (w_load) begin
          r_lanes[gi] <= w_pattern[gi*SONG_LEN +: SONG_LEN];
        end else if (w_advance) begin
          r_lanes[gi] <= {r_lanes[gi][SONG_LEN-2:0], 1'b0};
        end
      end

      assign note_now[gi]                     = r_lanes[gi][SONG_LEN-1];
      assign lane_window[gi*WINDOW +: WINDOW] = r_lanes[gi][SONG_LEN-1 -: WINDOW];
    end
  endgenerate

  assign beat_pulse = r_beat_pulse;
  assign beat_idx   = r_beat_idx;
  assign sel_err    = r_sel_err;
  assign playing    = (r_state == ST_LOAD) || (r_state == ST_PLAY) || (r_state == ST_PAUSED);
  assign done       = (r_state == ST_DONE);

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Plays a selected song as a timed stream of per-lane note bits for the drum game.
- Song patterns come from an internal ROM. On start, the selected pattern is loaded into per-lane shift registers and advanced one beat per TICKS_PER_BEAT clocks.
- Feeds the current-note lines to hit-judge logic and a look-ahead window to the note-highway renderer. Adds pause, abort, a done flag and select validation.

Parameters:
- NUM_LANES, 3, number of note lanes (lane 0 = red, lane 1 = yellow, lane 2 = blue).
- SONG_LEN, 100, beats per song. Bit SONG_LEN-1 is beat 0.
- NUM_SONGS, 4, number of ROM entries.
- SEL_W, 5, song_select width.
- TICKS_PER_BEAT, 12500000, clocks per beat (0.25 s at 50 MHz). Must be ≥ 2.
- WINDOW, 16, upcoming beats exposed per lane. Must be ≤ SONG_LEN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  begin playback of song_select; sampled in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- pause  in  1  level; freezes playback while high in PLAY.
- song_select  in  SEL_W  song index; latched on accepted start.
- note_now  out  NUM_LANES  note bits for the current beat, one per lane.
- lane_window  out  NUM_LANES*WINDOW  lane L occupies [L*WINDOW +: WINDOW]; the MSB of that field is the current beat.
- beat_pulse  out  1  one-cycle strobe on each beat advance.
- beat_idx  out  7  current beat number, 0..SONG_LEN-1.
- playing  out  1  high in LOAD, PLAY and PAUSED.
- done  out  1  high in DONE.
- sel_err  out  1  one-cycle strobe when start is rejected.

Behaviour:
- Reset (async, resetn=0): state IDLE. All shift registers, tick counter, beat_idx and the latched select are cleared. All outputs are 0.
- States: IDLE, LOAD, PLAY, PAUSED, DONE. Encoding lives in the package.
- IDLE:
  - start with song_select < NUM_SONGS: latch the select, go to LOAD.
  - start with song_select ≥ NUM_SONGS: stay in IDLE, sel_err=1 for one cycle.
- LOAD (exactly 1 cycle):
  - Shift regs ← ROM[latched select].
  - tick ← 0, beat_idx ← 0.
  - Next state PLAY.
  - note_now is valid from the first PLAY cycle, i.e. 2 cycles after start.
- PLAY:
  - tick increments each cycle.
  - When tick = TICKS_PER_BEAT-1: tick ← 0, beat_pulse=1 for that cycle, and on the same edge every lane shifts left one bit with 0 shifted in.
  - On that same edge, if beat_idx = SONG_LEN-1 go to DONE; otherwise beat_idx increments.
- PAUSED:
  - Entered when pause=1 in PLAY, and taken in preference to a pending beat edge.
  - tick, shift regs and beat_idx hold.
  - Returns to PLAY the cycle after pause=0; the tick count resumes from where it stopped.
- DONE:
  - done=1; shift regs are all zero; beat_idx holds SONG_LEN-1.
  - start re-validates the select and goes to LOAD, or raises sel_err and stays in DONE.
- abort:
  - From any state, go to IDLE next cycle and clear everything as at reset.
  - abort has priority over start and pause in the same cycle.
- start in LOAD, PLAY or PAUSED is ignored; the song is not restarted.
- pause in IDLE or DONE is ignored.
- Output derivation:
  - note_now[L] = MSB of lane L's shift register.
  - lane_window field L = the top WINDOW bits of lane L. Beats beyond SONG_LEN read as 0.
- All outputs are registered or decoded directly from registered state. No combinational path from inputs to outputs.

Decomposition:
- Package song_pkg holds the state encoding, lane index constants (LANE_RED=0, LANE_YELLOW=1, LANE_BLUE=2) and song IDs. SONG_TTFAF = 0 is the initial mapping; the mapping is set in the package and the ROM must use the same IDs.
- Sub-module song_rom: combinational. Ports song_id in, pattern out (NUM_LANES*SONG_LEN). Unlisted IDs return all zeros.
- Song 0 content, SONG_LEN=100:
  - red: beats 0-9 zero, then 1 on every even beat from 10.
  - yellow: 1 on beats 11, 15, 19, … 99.
  - blue: 1 on beats 13, 17, … 97.

Test Plan:
- Reset mid-play: assert resetn=0 during PLAY → all outputs 0 immediately (asynchronously), state IDLE after release.
- Start song 0, TICKS_PER_BEAT=4:
  - note_now=000 at beats 0-9.
  - Beat 10 → red=1; beat 11 → yellow=1; beat 13 → blue=1.
  - beat_pulse every 4 clocks.
  - done=1 after 100 beats (400 clocks + 1 LOAD cycle).
- Pause: hold pause for 10 cycles at beat 20, tick=2 → beat_idx stays 20, no beat_pulse. After release, the next beat_pulse comes 2 cycles after PLAY resumes.
- Invalid select: song_select=7 with start in IDLE → sel_err one cycle, playing stays 0. The same check applies from DONE.
- Simultaneous events:
  - abort+start in the same cycle in PLAY → IDLE, all cleared.
  - start during PLAY → ignored, beat_idx continues.
- Window: at beat 10 of song 0 → red field = 1010101010101010b, yellow field = 0100010001000100b, blue field = 0001000100010001b.
